// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: stall bus encodings,
// multi-cycle FSM state codes and the stall priority encoder.
package pipeline_stall_ctrl_pkg;

  localparam int unsigned StallBusW   = 6;
  localparam int unsigned InstAddrBus = 32;

  // Bit order: [0]pc [1]if [2]id [3]ex [4]mem [5]wb; 1 = hold
  localparam logic [StallBusW-1:0] StallNone = 6'b000000;
  localparam logic [StallBusW-1:0] StallId   = 6'b000111;
  localparam logic [StallBusW-1:0] StallEx   = 6'b001111;
  localparam logic [StallBusW-1:0] StallMem  = 6'b011111;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } mc_state_e;

  // Flush beats everything so no stale op is held across a redirect.
  function automatic logic [StallBusW-1:0] stall_encode(input logic flush,
                                                        input logic mem_wait,
                                                        input logic ex_hold,
                                                        input logic id_hold);
    logic [StallBusW-1:0] vec;
    if (flush == Stop) begin
      vec = StallNone;
    end else if (mem_wait == Stop) begin
      vec = StallMem;
    end else if (ex_hold == Stop) begin
      vec = StallEx;
    end else if (id_hold == Stop) begin
      vec = StallId;
    end else begin
      vec = StallNone;
    end
    return vec;
  endfunction

endpackage

// File: rtl/stall_perf_cnt.sv
// 32-bit saturating event counter; counts cycles where en_i is high, cleared only by rst.
module stall_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  output logic [31:0] cnt_o
);

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush controller around decode: merges stall sources into one stall vector,
// sequences multi-cycle EX ops and redirects fetch on flush.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int unsigned MC_CYCLES = 32,
  parameter int unsigned CNT_W     = 6,
  parameter int unsigned PC_W      = InstAddrBus
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stallreq_id,
  input  logic            ex_mc_start,
  input  logic            mem_stall,
  input  logic            flush_req,
  input  logic [PC_W-1:0] flush_pc,
  output logic [5:0]      stall_o,
  output logic            ex_mc_done_o,
  output logic            flush_o,
  output logic [PC_W-1:0] new_pc_o,
  output logic [31:0]     stall_cycles_o
);

  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(MC_CYCLES - 1);

  mc_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flush_q, flush_d;
  logic [PC_W-1:0]  new_pc_q, new_pc_d;

  always_comb begin
    if (rst) begin
      stall_o = StallNone;
    end else begin
      stall_o = stall_encode(flush_req, mem_stall, ex_mc_start || (state_q == StBusy),
                             stallreq_id);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    flush_d  = 1'b0;
    new_pc_d = new_pc_q;
    if (flush_req) begin
      // Abort any in-flight op; a start in the same cycle is dropped.
      state_d  = StIdle;
      cnt_d    = '0;
      flush_d  = 1'b1;
      new_pc_d = flush_pc;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ex_mc_start) begin
            state_d = StBusy;
            cnt_d   = CntLoad;
          end
        end
        StBusy: begin
          if (cnt_q == '0) begin
            state_d = StDone;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        StDone: begin
          // Result must stay valid while the memory stage holds the pipe.
          if (!mem_stall) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      flush_q  <= 1'b0;
      new_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      flush_q  <= flush_d;
      new_pc_q <= new_pc_d;
    end
  end

  assign ex_mc_done_o = (state_q == StDone);
  assign flush_o      = flush_q;
  assign new_pc_o     = new_pc_q;

  stall_perf_cnt u_perf_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (stall_o[0]),
    .cnt_o (stall_cycles_o)
  );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: cycle model feeds a scoreboard of expected
// registered outputs; stall_o is checked combinationally within the driven cycle.
module tb_pipeline_stall_ctrl;

  localparam int unsigned Mc = 4;
  localparam int unsigned Cw = 3;
  localparam int unsigned Pw = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stallreq_id = 1'b0;
  logic          ex_mc_start = 1'b0;
  logic          mem_stall = 1'b0;
  logic          flush_req = 1'b0;
  logic [Pw-1:0] flush_pc = '0;
  logic [5:0]    stall_o;
  logic          ex_mc_done_o;
  logic          flush_o;
  logic [Pw-1:0] new_pc_o;
  logic [31:0]   stall_cycles_o;

  pipeline_stall_ctrl #(
    .MC_CYCLES (Mc),
    .CNT_W     (Cw),
    .PC_W      (Pw)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stallreq_id    (stallreq_id),
    .ex_mc_start    (ex_mc_start),
    .mem_stall      (mem_stall),
    .flush_req      (flush_req),
    .flush_pc       (flush_pc),
    .stall_o        (stall_o),
    .ex_mc_done_o   (ex_mc_done_o),
    .flush_o        (flush_o),
    .new_pc_o       (new_pc_o),
    .stall_cycles_o (stall_cycles_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        done;
    logic        flush;
    logic [31:0] pc;
    logic [31:0] sc;
    logic        chk_sc;
  } exp_t;

  exp_t sb_q[$];

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state: 0 idle, 1 busy, 2 done
  int          m_state = 0;
  int          m_cnt   = 0;
  logic        m_flush = 1'b0;
  logic [31:0] m_pc    = '0;
  logic [31:0] m_sc    = '0;
  logic        sc_known = 1'b1;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic id, input logic st, input logic ms,
                     input logic fr, input logic [31:0] fp);
    logic [5:0] exp_stall;
    exp_t       e;
    @(negedge clk);
    rst = r; stallreq_id = id; ex_mc_start = st; mem_stall = ms;
    flush_req = fr; flush_pc = fp;
    #1;
    if (r)                     exp_stall = 6'b000000;
    else if (fr)               exp_stall = 6'b000000;
    else if (ms)               exp_stall = 6'b011111;
    else if (st || m_state == 1) exp_stall = 6'b001111;
    else if (id)               exp_stall = 6'b000111;
    else                       exp_stall = 6'b000000;
    check_val("stall_o", 32'(stall_o), 32'(exp_stall));

    if (r) begin
      m_state = 0; m_cnt = 0; m_flush = 1'b0; m_pc = '0; m_sc = '0; sc_known = 1'b1;
    end else begin
      if (exp_stall[0] && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
      if (fr) begin
        m_state = 0; m_cnt = 0; m_flush = 1'b1; m_pc = fp;
      end else begin
        m_flush = 1'b0;
        case (m_state)
          0: if (st) begin m_state = 1; m_cnt = Mc - 1; end
          1: if (m_cnt == 0) m_state = 2; else m_cnt = m_cnt - 1;
          2: if (!ms) m_state = 0;
          default: m_state = 0;
        endcase
      end
    end
    sb_q.push_back('{done: (m_state == 2), flush: m_flush, pc: m_pc, sc: m_sc,
                     chk_sc: sc_known});

    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_val("ex_mc_done_o", 32'(ex_mc_done_o), 32'(e.done));
    check_val("flush_o", 32'(flush_o), 32'(e.flush));
    check_val("new_pc_o", new_pc_o, e.pc);
    if (e.chk_sc) check_val("stall_cycles_o", stall_cycles_o, e.sc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    // 1: reset with random inputs
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
    // 2: single-cycle decode stall
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    idle(2);
    // 3: plain multi-cycle op
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    idle(7);
    // 4: mem_stall over the tail of the op and DONE
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    idle(3);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    idle(3);
    // 5: flush at t2 aborts op
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    idle(1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0040);
    idle(6);
    // back-to-back flushes, flush+start in idle, start while busy ignored
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1000);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_2000);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_3000);
    idle(2);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    idle(5);
    // reset mid-op
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    idle(2);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    idle(3);
    // random traffic
    for (int i = 0; i < 400; i++)
      cyc(1'b0, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
          1'($urandom_range(0, 9) < 2), 1'($urandom_range(0, 19) == 0), $urandom);
    // 6: saturation via counter preload
    sc_known = 1'b0;
    @(negedge clk);
    force dut.u_perf_cnt.cnt_q = 32'hFFFF_FFF0;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    release dut.u_perf_cnt.cnt_q;
    for (int i = 0; i < 25; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    m_sc = 32'hFFFF_FFFF;
    sc_known = 1'b1;
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    idle(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
